// File: rtl/serial_tx_control.sv
// Transmit-side control FSM of the 8051-style serial port: serialises SBUF in
// SCON modes 0..3, drives TXD/RXD pin data and port-3 enables, pulses TI at end.
module serial_tx_control #(
  parameter int DATA_W = 8
) (
  input  logic              serial_clock_i,
  input  logic              serial_reset_i_b,
  input  logic              serial_br_i,
  input  logic              serial_scon7_sm0_i,
  input  logic              serial_scon6_sm1_i,
  input  logic              serial_scon3_tb8_i,
  input  logic              serial_write_sbuf_i,
  input  logic [DATA_W-1:0] serial_sbuf_data_i,
  output logic              serial_txd_o,
  output logic              serial_rxd_o,
  output logic              serial_p3en_0_o,
  output logic              serial_p3en_1_o,
  output logic              serial_scon1_ti_o,
  output logic              serial_busy_o
);

  // Mode 0 needs 2*DATA_W ticks before DONE; the counter holds ticks after the first.
  localparam int CNT_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, ARMED, START, DATA, BIT9, STOP, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W:0]   shift_reg, shift_next;
  logic [1:0]        mode_reg, mode_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              txd_reg, txd_next;
  logic              rxd_reg, rxd_next;
  logic              p3en_0_reg, p3en_0_next;
  logic              p3en_1_reg, p3en_1_next;
  logic              ti_reg, ti_next;
  logic              busy_reg, busy_next;
  logic              frame_end;

  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      mode_reg   <= '0;
      cnt_reg    <= '0;
      txd_reg    <= 1'b1;
      rxd_reg    <= 1'b1;
      p3en_0_reg <= 1'b0;
      p3en_1_reg <= 1'b0;
      ti_reg     <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      mode_reg   <= mode_next;
      cnt_reg    <= cnt_next;
      txd_reg    <= txd_next;
      rxd_reg    <= rxd_next;
      p3en_0_reg <= p3en_0_next;
      p3en_1_reg <= p3en_1_next;
      ti_reg     <= ti_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    mode_next   = mode_reg;
    cnt_next    = cnt_reg;
    txd_next    = txd_reg;
    rxd_next    = rxd_reg;
    p3en_0_next = p3en_0_reg;
    p3en_1_next = p3en_1_reg;
    ti_next     = 1'b0;
    busy_next   = busy_reg;
    frame_end   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (serial_write_sbuf_i) begin
          // tb8 rides above the data so it falls out of the shifter as the 9th bit
          shift_next = {serial_scon3_tb8_i, serial_sbuf_data_i};
          mode_next  = {serial_scon7_sm0_i, serial_scon6_sm1_i};
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (serial_br_i) begin
          cnt_next    = '0;
          txd_next    = 1'b0;
          p3en_1_next = 1'b1;
          if (mode_reg == 2'b00) begin
            rxd_next    = shift_reg[0];
            shift_next  = {1'b0, shift_reg[DATA_W:1]};
            p3en_0_next = 1'b1;
            state_next  = DATA;
          end else begin
            state_next = START;
          end
        end
      end
      START: begin
        if (serial_br_i) begin
          txd_next   = shift_reg[0];
          shift_next = {1'b0, shift_reg[DATA_W:1]};
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = DATA;
        end
      end
      DATA: begin
        if (serial_br_i) begin
          if (mode_reg == 2'b00) begin
            if (cnt_reg == CNT_W'(2 * DATA_W - 1)) begin
              frame_end = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
              // odd counter value here means an odd tick: present the next bit, clock low
              if (cnt_reg[0]) begin
                rxd_next   = shift_reg[0];
                shift_next = {1'b0, shift_reg[DATA_W:1]};
                txd_next   = 1'b0;
              end else begin
                txd_next = 1'b1;
              end
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(DATA_W)) begin
              txd_next   = mode_reg[1] ? shift_reg[0] : 1'b1;
              state_next = mode_reg[1] ? BIT9 : STOP;
            end else begin
              txd_next   = shift_reg[0];
              shift_next = {1'b0, shift_reg[DATA_W:1]};
            end
          end
        end
      end
      BIT9: begin
        if (serial_br_i) begin
          txd_next   = 1'b1;
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = STOP;
        end
      end
      STOP: begin
        if (serial_br_i) begin
          frame_end = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (frame_end) begin
      state_next  = DONE;
      cnt_next    = '0;
      txd_next    = 1'b1;
      rxd_next    = 1'b1;
      p3en_0_next = 1'b0;
      p3en_1_next = 1'b0;
      ti_next     = 1'b1;
      busy_next   = 1'b0;
    end
  end

  assign serial_txd_o      = txd_reg;
  assign serial_rxd_o      = rxd_reg;
  assign serial_p3en_0_o   = p3en_0_reg;
  assign serial_p3en_1_o   = p3en_1_reg;
  assign serial_scon1_ti_o = ti_reg;
  assign serial_busy_o     = busy_reg;

endmodule

// File: tb/tb_serial_tx_control.sv
// Self-checking bench for serial_tx_control: table of frames plus hand-written
// corner sequences; per-tick expected pin values go through a scoreboard queue.
module tb_serial_tx_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       br = 1'b0;
  logic       sm0 = 1'b0;
  logic       sm1 = 1'b0;
  logic       tb8 = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       txd, rxd, p3en_0, p3en_1, ti, busy;

  serial_tx_control #(.DATA_W(8)) dut (
    .serial_clock_i      (clk),
    .serial_reset_i_b    (rst_n),
    .serial_br_i         (br),
    .serial_scon7_sm0_i  (sm0),
    .serial_scon6_sm1_i  (sm1),
    .serial_scon3_tb8_i  (tb8),
    .serial_write_sbuf_i (wr),
    .serial_sbuf_data_i  (din),
    .serial_txd_o        (txd),
    .serial_rxd_o        (rxd),
    .serial_p3en_0_o     (p3en_0),
    .serial_p3en_1_o     (p3en_1),
    .serial_scon1_ti_o   (ti),
    .serial_busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic txd;
    logic rxd;
    logic p0;
    logic p1;
    logic ti;
    logic busy;
  } pins_t;

  typedef struct {
    logic [1:0] mode;
    logic       tb8;
    logic [7:0] data;
    int         last;       // tick index at which TI must pulse
    int         inject_k;   // tick at which a stray write + SCON change is made (0 = none)
    bit         coinc;      // write coincident with a br tick
    bit         wr_on_done; // write in the DONE cycle (must be ignored)
  } vec_t;

  localparam pins_t IDLE_PINS = '{txd: 1'b1, rxd: 1'b1, p0: 1'b0, p1: 1'b0, ti: 1'b0, busy: 1'b0};

  pins_t q[$];
  int    checks = 0;
  int    passes = 0;
  int    ti_cnt = 0;

  always @(posedge clk) if (ti === 1'b1) ti_cnt <= ti_cnt + 1;

  function automatic pins_t cur();
    return '{txd: txd, rxd: rxd, p0: p3en_0, p1: p3en_1, ti: ti, busy: busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Pin values expected just after tick k of a frame, straight from the frame format.
  function automatic pins_t model(input logic [1:0] mode, input logic tb8v,
                                  input logic [7:0] data, input int last, input int k);
    pins_t p;
    if (k == last) return '{txd: 1'b1, rxd: 1'b1, p0: 1'b0, p1: 1'b0, ti: 1'b1, busy: 1'b0};
    p.ti = 1'b0;
    p.busy = 1'b1;
    p.p1 = 1'b1;
    if (mode == 2'b00) begin
      p.p0 = 1'b1;
      p.txd = (k % 2 == 0);
      p.rxd = data[(k - 1) / 2];
    end else begin
      p.p0 = 1'b0;
      p.rxd = 1'b1;
      if (k == 1) p.txd = 1'b0;
      else if (k <= 9) p.txd = data[k - 2];
      else if (k == 10 && mode != 2'b01) p.txd = tb8v;
      else p.txd = 1'b1;
    end
    return p;
  endfunction

  // Leaves the bench at the negedge right after the tick edge.
  task automatic tick(input pins_t e, input string name, input logic wr_too);
    pins_t x;
    q.push_back(e);
    repeat (3) @(negedge clk);
    br = 1'b1;
    wr = wr_too;
    @(negedge clk);
    br = 1'b0;
    wr = 1'b0;
    x = q.pop_front();
    check(name, 32'(cur()), 32'(x));
  endtask

  task automatic load(input logic [1:0] mode, input logic tb8v, input logic [7:0] data,
                      input bit coinc);
    @(negedge clk);
    wr = 1'b1;
    din = data;
    {sm0, sm1} = mode;
    tb8 = tb8v;
    br = coinc;
    @(negedge clk);
    wr = 1'b0;
    br = 1'b0;
    // scramble SCON and data: only the values latched at load may matter
    {sm0, sm1} = ~mode;
    tb8 = ~tb8v;
    din = ~data;
    check("busy_on_load", 32'(busy), 32'd1);
    if (coinc) check("coinc_tick_ignored", 32'({txd, p3en_1}), 32'b10);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int base;
    repeat (2) @(negedge clk);
    base = ti_cnt;
    load(v.mode, v.tb8, v.data, v.coinc);
    for (int k = 1; k <= v.last; k++) begin
      if (k == v.inject_k) begin
        din = 8'hFF;
        {sm0, sm1} = 2'b10;
      end
      tick(model(v.mode, v.tb8, v.data, v.last, k), $sformatf("v%0d_tick%0d", idx, k),
           k == v.inject_k);
    end
    if (v.wr_on_done) begin
      wr = 1'b1;
      din = 8'h5A;
      @(negedge clk);
      wr = 1'b0;
      check($sformatf("v%0d_wr_on_done_ignored", idx), 32'({ti, busy}), 32'b00);
    end
    repeat (2) @(negedge clk);
    check($sformatf("v%0d_ti_once", idx), 32'(ti_cnt - base), 32'd1);
    check($sformatf("v%0d_idle_after", idx), 32'(cur()), 32'(IDLE_PINS));
    tick(IDLE_PINS, $sformatf("v%0d_no_second_frame", idx), 1'b0);
    check($sformatf("v%0d_ti_still_once", idx), 32'(ti_cnt - base), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    int base;
    vec_t v;
    vecs[0] = '{mode: 2'b01, tb8: 1'b0, data: 8'hA5, last: 11, inject_k: 0, coinc: 0, wr_on_done: 0};
    vecs[1] = '{mode: 2'b10, tb8: 1'b1, data: 8'h3C, last: 12, inject_k: 0, coinc: 0, wr_on_done: 0};
    vecs[2] = '{mode: 2'b11, tb8: 1'b0, data: 8'hC3, last: 12, inject_k: 0, coinc: 0, wr_on_done: 0};
    vecs[3] = '{mode: 2'b00, tb8: 1'b0, data: 8'h3C, last: 17, inject_k: 0, coinc: 0, wr_on_done: 0};
    vecs[4] = '{mode: 2'b01, tb8: 1'b0, data: 8'h55, last: 11, inject_k: 4, coinc: 0, wr_on_done: 0};
    vecs[5] = '{mode: 2'b01, tb8: 1'b1, data: 8'hC3, last: 11, inject_k: 0, coinc: 1, wr_on_done: 1};

    #7;
    check("reset_pins", 32'(cur()), 32'(IDLE_PINS));
    @(negedge clk);
    rst_n = 1'b1;
    tick(IDLE_PINS, "idle_tick_no_effect", 1'b0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // asynchronous reset during tick 6 of a mode 1 frame
    base = ti_cnt;
    load(2'b01, 1'b0, 8'h96, 1'b0);
    for (int k = 1; k <= 5; k++)
      tick(model(2'b01, 1'b0, 8'h96, 11, k), $sformatf("rst_frame_tick%0d", k), 1'b0);
    repeat (3) @(negedge clk);
    br = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_reset_pins", 32'(cur()), 32'(IDLE_PINS));
    @(negedge clk);
    br = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick(IDLE_PINS, $sformatf("post_reset_idle%0d", k), 1'b0);
    check("no_ti_after_reset", 32'(ti_cnt - base), 32'd0);

    v = '{mode: 2'b01, tb8: 1'b0, data: 8'h81, last: 11, inject_k: 0, coinc: 0, wr_on_done: 0};
    run_frame(v, 6);

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_control.md
Name: serial_tx_control

Overview:
Transmit-side control FSM of the EMC08 8051-compatible serial port. It pairs with serial_rx_control. It serialises the byte written to SBUF according to SCON mode (0..3), drives the TXD/RXD pin data and port-3 output enables, and sets TI when the frame completes. The baud generator upstream supplies a bit-rate tick (serial_br_i); the 16x oversampling divide is done outside this block.

Parameters:
DATA_W, 8, SBUF data width (fixed at 8 for 8051 compatibility; parameterised only for the bit counter width)

Ports:
serial_clock_i  input  1  system clock, all state updates on the rising edge
serial_reset_i_b  input  1  asynchronous active-low reset
serial_br_i  input  1  bit-rate tick, one clock wide; one tick = one bit time (mode 0: one half bit)
serial_scon7_sm0_i  input  1  SCON.SM0
serial_scon6_sm1_i  input  1  SCON.SM1
serial_scon3_tb8_i  input  1  9th data bit for modes 2/3
serial_write_sbuf_i  input  1  one-cycle pulse: CPU wrote SBUF, starts transmission
serial_sbuf_data_i  input  8  byte to transmit, valid with write pulse
serial_txd_o  output  1  TXD pin data: serial data (modes 1-3) or shift clock (mode 0)
serial_rxd_o  output  1  RXD pin data: serial data in mode 0 only
serial_p3en_0_o  output  1  1 = block drives RXD (P3.0)
serial_p3en_1_o  output  1  1 = block drives TXD (P3.1)
serial_scon1_ti_o  output  1  one-cycle pulse: set SCON.TI
serial_busy_o  output  1  frame in progress

Behaviour:
- Reset (async, serial_reset_i_b=0): state IDLE; txd_o=1, rxd_o=1, p3en_0_o=0, p3en_1_o=0, ti_o=0, busy_o=0; shift register and counter cleared.
- States: IDLE, ARMED, START, DATA, BIT9, STOP, DONE.
- IDLE: on write_sbuf_i=1, latch data into the 9-bit shift register, latch {sm0,sm1} and tb8, and go to ARMED. busy_o=1 from the next edge.
- Mode, tb8 and data are sampled only at load. SCON changes mid-frame have no effect.
- ARMED: wait for the next br tick. A tick in the same cycle as the write is ignored, so the first bit always gets a full width.
- Modes 1/2/3, one bit per tick:
  - Tick 1: START, txd_o=0, p3en_1_o=1.
  - Ticks 2-9: DATA, D0..D7, LSB first.
  - Modes 2/3 only: tick 10: BIT9, txd_o=latched tb8.
  - Next tick: STOP, txd_o=1.
  - Next tick: DONE. ti_o=1 for exactly one clock, busy_o=0, p3en_1_o=0, state IDLE.
  - Total ticks: mode 1 = 11, modes 2/3 = 12.
- Mode 0 (sm0=0, sm1=0), two ticks per bit, 8 bits, LSB first:
  - Odd tick: rxd_o=Dn, txd_o=0.
  - Even tick: txd_o=1; the external device samples on this rising edge.
  - p3en_0_o=1 and p3en_1_o=1 from tick 1 until DONE.
  - Tick 17: DONE, ti_o pulse, both enables drop, txd_o=1, rxd_o=1.
- Bit counter is 4 bits, counts ticks within a frame, cleared at load and at DONE. It never wraps within a legal frame.
- Outputs are registered and change only on the clock edge at which br_i=1, except ti_o (DONE edge) and busy_o (load edge).
- write_sbuf_i while busy_o=1: ignored. No reload and no restart; the frame in flight completes unchanged.
- write_sbuf_i in the same cycle as DONE: ignored. A new write is accepted from the cycle after DONE.
- Reset asserted mid-frame: immediately returns to the reset values, with no TI pulse. After deassertion the block waits for a new write.
- br_i with no frame pending: no effect.

Test Plan:
- Mode 1, write 0xA5, br tick every 4 clocks -> txd_o sequence 0,1,0,1,0,0,1,0,1,1 (start, D0..D7, stop) at successive ticks; ti_o pulses once at tick 11; busy_o low afterwards.
- Mode 2, write 0x3C with tb8=1 -> txd_o 0,0,0,1,1,1,1,0,0,1,1; ti_o at tick 12.
- Mode 3 with tb8=0 -> 9th bit is 0, stop bit is 1.
- Mode 0, write 0x3C -> rxd_o presents 0,0,1,1,1,1,0,0 on odd ticks; txd_o toggles 0/1 for 8 periods; p3en_0_o=p3en_1_o=1 throughout; ti_o at tick 17.
- Mode 1, write 0x55, then write 0xFF at tick 4 -> the frame still transmits 0x55, ti_o pulses once, and no second frame follows.
- Write coincident with a br tick -> the start bit begins at the following tick. SCON changed to mode 2 mid-frame -> the frame still ends after 11 ticks.
- Reset pulse at tick 6 of a mode 1 frame -> txd_o=1, all enables 0, no ti_o. A subsequent write of 0x81 transmits correctly.
